// File: rtl/fetch_unit.sv
// Instruction fetch stage: generates word-aligned fetch addresses, issues
// reads to a one-cycle-latency instruction memory and buffers the returned
// {inst, pc} pairs in a small circular prefetch queue drained by decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fetch_pc;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic          kill;
  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [CW:0]   used;
  logic [31:0]   target;
  logic          push;
  logic          pop;

  // Credit check, handshake and response-acceptance terms.
  always_comb begin
    used       = {1'b0, count} + (CW+1)'(inflight);
    target     = redirect_pc & ~32'd3;
    imem_req   = !rst && !redirect && (used < (CW+1)'(DEPTH));
    imem_addr  = rst ? RESET_PC : fetch_pc;
    inst_valid = !rst && (count != '0);
    inst       = q_inst[rd_ptr];
    inst_pc    = q_pc[rd_ptr];
    pop        = inst_valid && inst_ready;
    // A response arriving in a redirect cycle belongs to the flushed stream.
    push       = !rst && inflight && !kill && !redirect;
  end

  // Fetch PC, in-flight tracking and queue pointer/occupancy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      kill        <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      inflight <= imem_req;
      kill     <= redirect;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (redirect) begin
        fetch_pc <= target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default instance (RESET_PC = 0) and a
// second instance whose reset PC sits just below the 32-bit wrap point.
// Memory model returns the requested address as the instruction word.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b1;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc;

  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = '0;
  logic        inst_ready2 = 1'b1;
  logic        imem_req2, inst_valid2;
  logic [31:0] imem_addr2, imem_rdata2, inst2, inst_pc2;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
    .inst_ready(inst_ready2)
  );

  always #5 clk = ~clk;

  // One-cycle-latency instruction memory: word = address.
  always @(posedge clk) begin
    imem_rdata  <= imem_addr;
    imem_rdata2 <= imem_addr2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    inst_ready  = rdy;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);

    // Reset values
    drive(1, 0, 0, 1);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_addr_wrap", imem_addr2, 32'hFFFF_FFF8);
    next_cycle();

    // Reset release, streaming with inst_ready = 1; wrap instance in parallel
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 1);
      chk("t1_req", 32'(imem_req), 1);
      chk("t1_addr", imem_addr, 32'(4 * k));
      chk("t1_valid", 32'(inst_valid), 32'(k >= 2));
      if (k >= 2) begin
        chk("t1_pc", inst_pc, 32'(4 * (k - 2)));
        chk("t1_inst", inst, 32'(4 * (k - 2)));
      end
      if (k >= 2 && k <= 4) begin
        chk("wrap_pc", inst_pc2, 32'hFFFF_FFF8 + 32'(4 * (k - 2)));
        chk("wrap_inst", inst2, 32'hFFFF_FFF8 + 32'(4 * (k - 2)));
      end
      next_cycle();
    end

    // Mid-stream reset
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0);
      chk("mrst_req", 32'(imem_req), 0);
      chk("mrst_valid", 32'(inst_valid), 0);
      chk("mrst_valid_wrap", 32'(inst_valid2), 0);
      next_cycle();
    end

    // Stall: four requests fill the queue, then the request line holds low
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, 0);
      chk("stall_req", 32'(imem_req), 32'(k < 4));
      if (k == 0) begin
        chk("restart_addr", imem_addr, 32'h0);
        chk("restart_addr_wrap", imem_addr2, 32'hFFFF_FFF8);
      end
      if (k == 9) begin
        chk("stall_valid", 32'(inst_valid), 1);
        chk("stall_head", inst_pc, 32'h0);
      end
      next_cycle();
    end
    // Release: PCs 0..16 on consecutive cycles
    for (int j = 0; j < 5; j++) begin
      drive(0, 0, 0, 1);
      chk("drain_valid", 32'(inst_valid), 1);
      chk("drain_pc", inst_pc, 32'(4 * j));
      next_cycle();
    end

    // Redirect to 0x100 with 3 buffered and 1 in flight
    drive(1, 0, 0, 0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0);
      chk("fill_req", 32'(imem_req), 1);
      chk("fill_addr", imem_addr, 32'(4 * k));
      next_cycle();
    end
    drive(0, 1, 32'h100, 0);
    chk("r1_req", 32'(imem_req), 0);
    chk("r1_valid_pre", 32'(inst_valid), 1);
    chk("r1_head_pre", inst_pc, 32'h0);
    next_cycle();
    drive(0, 0, 0, 1);
    chk("r1_req1", 32'(imem_req), 1);
    chk("r1_addr1", imem_addr, 32'h100);
    chk("r1_valid1", 32'(inst_valid), 0);
    next_cycle();
    drive(0, 0, 0, 1);
    chk("r1_valid2", 32'(inst_valid), 0);
    chk("r1_addr2", imem_addr, 32'h104);
    next_cycle();
    drive(0, 0, 0, 1);
    chk("r1_valid3", 32'(inst_valid), 1);
    chk("r1_pc3", inst_pc, 32'h100);
    chk("r1_inst3", inst, 32'h100);
    next_cycle();

    // Redirect to 0x103 while 0x104 is handshaken
    drive(0, 1, 32'h103, 1);
    chk("r2_head", inst_pc, 32'h104);
    chk("r2_valid", 32'(inst_valid), 1);
    next_cycle();
    drive(0, 0, 0, 1);
    chk("r2_req1", 32'(imem_req), 1);
    chk("r2_addr1", imem_addr, 32'h100);
    chk("r2_valid1", 32'(inst_valid), 0);
    next_cycle();
    drive(0, 0, 0, 1);
    chk("r2_valid2", 32'(inst_valid), 0);
    next_cycle();
    drive(0, 0, 0, 1);
    chk("r2_valid3", 32'(inst_valid), 1);
    chk("r2_pc3", inst_pc, 32'h100);
    next_cycle();

    // Back-to-back redirects: 0x200 then 0x300
    drive(0, 1, 32'h200, 1);
    chk("bb_req_a", 32'(imem_req), 0);
    next_cycle();
    drive(0, 1, 32'h300, 1);
    chk("bb_req_b", 32'(imem_req), 0);
    chk("bb_valid_b", 32'(inst_valid), 0);
    next_cycle();
    drive(0, 0, 0, 1);
    chk("bb_addr1", imem_addr, 32'h300);
    chk("bb_req1", 32'(imem_req), 1);
    chk("bb_valid1", 32'(inst_valid), 0);
    next_cycle();
    drive(0, 0, 0, 1);
    chk("bb_valid2", 32'(inst_valid), 0);
    chk("bb_addr2", imem_addr, 32'h304);
    next_cycle();
    drive(0, 0, 0, 1);
    chk("bb_valid3", 32'(inst_valid), 1);
    chk("bb_pc3", inst_pc, 32'h300);
    chk("bb_inst3", inst, 32'h300);
    next_cycle();
    drive(0, 0, 0, 1);
    chk("bb_pc4", inst_pc, 32'h304);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
